// File: rtl/md4_pkg.sv
// Shared MD4 definitions: digest geometry, checker state encoding and the
// chaining-variable IV used by the hasher.
package md4_pkg;

  localparam int unsigned MD4_DIGEST_BYTES = 16;
  localparam int unsigned MD4_DIGEST_W     = 128;

  localparam logic [31:0] MD4_IV_A = 32'h67452301;
  localparam logic [31:0] MD4_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD4_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD4_IV_D = 32'h10325476;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_RESULT  = 2'd1,
    ST_HALT    = 2'd2
  } chk_state_e;

endpackage

// File: rtl/md4_digest_checker.sv
// Assembles the hasher's 16-byte digest stream, compares each digest with the
// loaded target and latches the index of the first matching candidate.
module md4_digest_checker
  import md4_pkg::*;
#(
  parameter int unsigned IDX_W         = 32,
  parameter bit          STOP_ON_MATCH = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [MD4_DIGEST_W-1:0] target_hash,
  input  logic                    target_load,
  input  logic [7:0]              in_byte,
  input  logic                    in_write,
  output logic                    in_ready,
  input  logic                    clear,
  output logic                    result_valid,
  output logic                    result_match,
  output logic [MD4_DIGEST_W-1:0] digest,
  output logic                    found,
  output logic [IDX_W-1:0]        found_index,
  output logic [IDX_W-1:0]        digest_count
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MD4_DIGEST_BYTES - 1);

  chk_state_e              state, state_next;
  logic [CNT_W-1:0]        byte_cnt, byte_cnt_next;
  logic [MD4_DIGEST_W-1:0] digest_sr, digest_sr_next;
  logic [MD4_DIGEST_W-1:0] target_q, target_next;
  logic [MD4_DIGEST_W-1:0] digest_next;
  logic [MD4_DIGEST_W-1:0] assembled_c;
  logic                    in_ready_next;
  logic                    result_valid_next;
  logic                    result_match_next;
  logic                    found_next;
  logic [IDX_W-1:0]        found_index_next;
  logic [IDX_W-1:0]        digest_count_next;
  logic                    accept_c;

  assign accept_c = in_write && in_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_COLLECT;
      byte_cnt     <= '0;
      digest_sr    <= '0;
      target_q     <= '0;
      in_ready     <= 1'b0;
      result_valid <= 1'b0;
      result_match <= 1'b0;
      digest       <= '0;
      found        <= 1'b0;
      found_index  <= '0;
      digest_count <= '0;
    end else begin
      state        <= state_next;
      byte_cnt     <= byte_cnt_next;
      digest_sr    <= digest_sr_next;
      target_q     <= target_next;
      in_ready     <= in_ready_next;
      result_valid <= result_valid_next;
      result_match <= result_match_next;
      digest       <= digest_next;
      found        <= found_next;
      found_index  <= found_index_next;
      digest_count <= digest_count_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next        = state;
    byte_cnt_next     = byte_cnt;
    digest_sr_next    = digest_sr;
    target_next       = target_load ? target_hash : target_q;
    result_valid_next = 1'b0;
    result_match_next = result_match;
    digest_next       = digest;
    found_next        = found;
    found_index_next  = found_index;
    digest_count_next = digest_count;

    assembled_c = digest_sr;
    assembled_c[{byte_cnt, 3'b000} +: 8] = in_byte;

    if (clear) begin
      state_next        = ST_COLLECT;
      byte_cnt_next     = '0;
      found_next        = 1'b0;
      found_index_next  = '0;
      digest_count_next = '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (accept_c) begin
            digest_sr_next = assembled_c;
            if (byte_cnt == LAST_BYTE) begin
              result_valid_next = 1'b1;
              result_match_next = (assembled_c == target_q);
              digest_next       = assembled_c;
              byte_cnt_next     = '0;
              state_next        = ST_RESULT;
            end else begin
              byte_cnt_next = CNT_W'(byte_cnt + CNT_W'(1));
            end
          end
        end
        ST_RESULT: begin
          digest_count_next = digest_count + IDX_W'(1);
          // Only the first hit since reset/clear names the candidate
          if (result_match && !found) begin
            found_next       = 1'b1;
            found_index_next = digest_count;
          end
          state_next = (result_match && STOP_ON_MATCH) ? ST_HALT : ST_COLLECT;
        end
        ST_HALT:  state_next = ST_HALT;
        default:  state_next = ST_COLLECT;
      endcase
    end

    in_ready_next = (state_next == ST_COLLECT);
  end

endmodule

// File: tb/tb_md4_digest_checker.sv
// Bench for md4_digest_checker: two instances (stop and run-on) checked every
// cycle against a byte-stream reference model, plus directed and table cases.
module tb_md4_digest_checker;

  localparam int unsigned W = 32;

  localparam logic [127:0] H_EMPTY = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
  localparam logic [127:0] H_ABC   = 128'ha448017aaf21d8525fc10ae87aa6729d;
  localparam logic [127:0] H_A     = 128'hbde52cb31de33e46245e05fbdb6fb24a;
  localparam logic [127:0] H_MD    = 128'hd9130a8164549fe818874806e1c7014b;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] target_hash;
  logic         target_load;
  logic [7:0]   in_byte;
  logic         in_write;
  logic         clear;

  logic         rdy0, rv0, rm0, fnd0;
  logic [127:0] dig0;
  logic [W-1:0] fidx0, cnt0;
  logic         rdy1, rv1, rm1, fnd1;
  logic [127:0] dig1;
  logic [W-1:0] fidx1, cnt1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  md4_digest_checker #(.IDX_W(W), .STOP_ON_MATCH(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .target_hash(target_hash), .target_load(target_load),
    .in_byte(in_byte), .in_write(in_write), .in_ready(rdy0), .clear(clear),
    .result_valid(rv0), .result_match(rm0), .digest(dig0), .found(fnd0),
    .found_index(fidx0), .digest_count(cnt0));

  md4_digest_checker #(.IDX_W(W), .STOP_ON_MATCH(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .target_hash(target_hash), .target_load(target_load),
    .in_byte(in_byte), .in_write(in_write), .in_ready(rdy1), .clear(clear),
    .result_valid(rv1), .result_match(rm1), .digest(dig1), .found(fnd1),
    .found_index(fidx1), .digest_count(cnt1));

  // Reference model: bytes shift in from the top so the first byte ends at [7:0]
  typedef struct packed {
    logic         ready;
    logic         rv;
    logic         rm;
    logic         found;
    logic         halted;
    logic [4:0]   n;
    logic [W-1:0] fidx;
    logic [W-1:0] cnt;
    logic [127:0] acc;
    logic [127:0] dig;
    logic [127:0] tgt;
  } model_t;

  model_t m0, m1;

  function automatic model_t step(model_t m, bit stop);
    model_t r = m;
    if (clear) begin
      r.n = '0; r.found = 1'b0; r.fidx = '0; r.cnt = '0;
      r.rv = 1'b0; r.halted = 1'b0; r.ready = 1'b1;
    end else if (m.rv) begin
      r.rv  = 1'b0;
      r.cnt = m.cnt + 32'd1;
      if (m.rm && !m.found) begin
        r.found = 1'b1;
        r.fidx  = m.cnt;
      end
      r.halted = m.rm && stop;
      r.ready  = !r.halted;
    end else if (m.halted) begin
      r.ready = 1'b0;
    end else begin
      r.ready = 1'b1;
      if (in_write && m.ready) begin
        r.acc = {in_byte, m.acc[127:8]};
        r.n   = m.n + 5'd1;
        if (r.n == 5'd16) begin
          r.dig   = r.acc;
          r.rm    = (r.acc == m.tgt);
          r.rv    = 1'b1;
          r.n     = '0;
          r.ready = 1'b0;
        end
      end
    end
    if (target_load) r.tgt = target_hash;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= step(m0, 1'b0);
      m1 <= step(m1, 1'b1);
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon0.in_ready", 128'(rdy0), 128'(m0.ready));
      check("mon0.result_valid", 128'(rv0), 128'(m0.rv));
      check("mon0.result_match", 128'(rm0), 128'(m0.rm));
      check("mon0.digest", dig0, m0.dig);
      check("mon0.found", 128'(fnd0), 128'(m0.found));
      check("mon0.found_index", 128'(fidx0), 128'(m0.fidx));
      check("mon0.digest_count", 128'(cnt0), 128'(m0.cnt));
      check("mon1.in_ready", 128'(rdy1), 128'(m1.ready));
      check("mon1.result_valid", 128'(rv1), 128'(m1.rv));
      check("mon1.result_match", 128'(rm1), 128'(m1.rm));
      check("mon1.digest", dig1, m1.dig);
      check("mon1.found", 128'(fnd1), 128'(m1.found));
      check("mon1.found_index", 128'(fidx1), 128'(m1.fidx));
      check("mon1.digest_count", 128'(cnt1), 128'(m1.cnt));
    end
  end

  function automatic logic [127:0] swap(input logic [127:0] c);
    logic [127:0] s;
    for (int i = 0; i < 16; i++) s[8*i +: 8] = c[127-8*i -: 8];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bit r;
    in_byte  = b;
    in_write = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = rdy0;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_write = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: in_ready never high (t=%0t)", $time);
    end
  endtask

  task automatic send_bytes(input logic [127:0] canon, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(canon[127-8*i -: 8]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load(input logic [127:0] canon);
    target_hash = swap(canon);
    target_load = 1'b1;
    tick();
    target_load = 1'b0;
  endtask

  typedef struct {
    logic [127:0] tgt;
    logic [127:0] data;
    logic         exp_match;
  } vec_t;

  vec_t vecs[6];
  int   pulses[3];
  int   npulse;
  int   idx;
  logic [127:0] e;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{H_EMPTY, H_EMPTY, 1'b1};
    vecs[1] = '{H_EMPTY, H_ABC,   1'b0};
    vecs[2] = '{H_ABC,   H_ABC,   1'b1};
    vecs[3] = '{H_A,     H_MD,    1'b0};
    vecs[4] = '{H_MD,    H_MD,    1'b1};
    vecs[5] = '{H_A,     H_A,     1'b1};

    reset_n = 1'b0; target_hash = '0; target_load = 1'b0;
    in_byte = '0; in_write = 1'b0; clear = 1'b0;
    repeat (3) tick();
    check("reset.in_ready", 128'(rdy0), 128'(0));
    check("reset.result_valid", 128'(rv0), 128'(0));
    check("reset.digest", dig0, 128'(0));
    check("reset.found", 128'(fnd1), 128'(0));
    check("reset.digest_count", 128'(cnt1), 128'(0));
    reset_n = 1'b1;
    mon_en  = 1'b1;
    check("reset.ready_before_edge", 128'(rdy0), 128'(0));
    tick();
    check("reset.ready_after_edge", 128'(rdy0), 128'(1));

    // Test 1: "" digest against its own hash, stop instance halts
    load(H_EMPTY);
    send_bytes(H_EMPTY, 0, 15);
    check("t1.result_valid", 128'(rv1), 128'(1));
    check("t1.result_match", 128'(rm1), 128'(1));
    check("t1.digest", dig1, swap(H_EMPTY));
    tick();
    check("t1.found", 128'(fnd1), 128'(1));
    check("t1.found_index", 128'(fidx1), 128'(0));
    repeat (5) tick();
    check("t1.halt_ready", 128'(rdy1), 128'(0));
    check("t1.run_on_ready", 128'(rdy0), 128'(1));

    // Test 2: "abc" then "" on the run-on instance
    do_clear();
    send_bytes(H_ABC, 0, 15);
    check("t2.first_match", 128'(rm0), 128'(0));
    send_bytes(H_EMPTY, 0, 15);
    check("t2.second_match", 128'(rm0), 128'(1));
    tick();
    check("t2.found_index", 128'(fidx0), 128'(1));
    check("t2.digest_count", 128'(cnt0), 128'(2));

    // Test 3: continuous writes give results spaced by 17 cycles
    do_clear();
    tick();
    npulse   = 0;
    in_write = 1'b1;
    for (int k = 0; k < 100 && npulse < 3; k++) begin
      in_byte = 8'($urandom);
      tick();
      if (rv0) begin
        pulses[npulse] = cyc;
        npulse++;
      end
    end
    in_write = 1'b0;
    check("t3.pulse_count", 128'(npulse), 128'(3));
    check("t3.gap1", 128'(pulses[1] - pulses[0]), 128'(17));
    check("t3.gap2", 128'(pulses[2] - pulses[1]), 128'(17));
    tick();
    check("t3.digest_count", 128'(cnt0), 128'(3));

    // Test 4: target load coincident with the 16th byte uses the old target
    do_clear();
    load(H_EMPTY);
    send_bytes(H_ABC, 0, 14);
    target_hash = swap(H_ABC);
    target_load = 1'b1;
    send_byte(H_ABC[7:0]);
    target_load = 1'b0;
    check("t4.old_target_match", 128'(rm0), 128'(0));
    send_bytes(H_ABC, 0, 15);
    check("t4.new_target_match", 128'(rm0), 128'(1));
    tick();
    check("t4.found_pre_clear", 128'(fnd0), 128'(1));

    // Test 5: clear with a write at byte_cnt 7 drops that byte
    send_bytes(H_ABC, 0, 6);
    in_byte  = 8'hee;
    in_write = 1'b1;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_write = 1'b0;
    check("t5.found", 128'(fnd0), 128'(0));
    check("t5.digest_count", 128'(cnt0), 128'(0));
    load(H_EMPTY);
    send_bytes(H_EMPTY, 0, 15);
    check("t5.match", 128'(rm0), 128'(1));
    check("t5.digest", dig0, swap(H_EMPTY));
    tick();
    check("t5.found_index", 128'(fidx0), 128'(0));
    check("t5.count", 128'(cnt0), 128'(1));

    // Table vectors
    foreach (vecs[i]) begin
      do_clear();
      load(vecs[i].tgt);
      send_bytes(vecs[i].data, 0, 15);
      check($sformatf("vec%0d.match0", i), 128'(rm0), 128'(vecs[i].exp_match));
      check($sformatf("vec%0d.match1", i), 128'(rm1), 128'(vecs[i].exp_match));
      check($sformatf("vec%0d.digest", i), dig0, swap(vecs[i].data));
      tick();
    end

    // Randomised traffic, half the time following the "" byte sequence
    do_clear();
    e = H_EMPTY;
    for (int k = 0; k < 800; k++) begin
      in_write    = ($urandom_range(0, 3) != 0);
      idx         = int'(m0.n);
      in_byte     = ($urandom_range(0, 1) == 0) ? e[127-8*idx -: 8] : 8'($urandom);
      clear       = ($urandom_range(0, 79) == 0);
      target_load = ($urandom_range(0, 29) == 0);
      target_hash = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom, $urandom}
                                                : swap(H_EMPTY);
      if ($urandom_range(0, 1) == 0) begin
        in_byte = e[127-8*idx -: 8];
        in_write = 1'b1;
      end
      tick();
    end
    in_write = 1'b0; clear = 1'b0; target_load = 1'b0;
    repeat (3) tick();

    // Test 6: asynchronous reset in the middle of a digest
    do_clear();
    load(H_EMPTY);
    send_bytes(H_EMPTY, 0, 8);
    reset_n = 1'b0;
    #1;
    check("t6.in_ready", 128'(rdy0), 128'(0));
    check("t6.result_match", 128'(rm0), 128'(0));
    check("t6.digest", dig0, 128'(0));
    check("t6.found", 128'(fnd0), 128'(0));
    check("t6.found_index", 128'(fidx1), 128'(0));
    check("t6.digest_count", 128'(cnt0), 128'(0));
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    send_bytes(H_EMPTY, 0, 15);
    check("t6.result_valid", 128'(rv0), 128'(1));
    check("t6.zero_target_match", 128'(rm0), 128'(0));
    check("t6.digest_after", dig0, swap(H_EMPTY));
    tick();
    check("t6.count_after", 128'(cnt0), 128'(1));

    repeat (2) tick();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
